mux_arb_2x1: RTL and testbench

MUX_ARB_2X1 -- requirements
Module: mux_arb_2x1

---
 rtl/mux_arb_2x1.sv | 88 ++++++++
 tb/tb_mux_arb_2x1.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_2x1.sv
// mux_arb_2x1: two-input round-robin arbiter feeding a single output register.
// Each source offers words with valid/ready. The winner's word is captured into
// the output register together with the index of the source that produced it.
// When both sources are valid, the one that did not win last time is chosen.
// The output register refills whenever it is empty or being drained this cycle,
// which sustains one word per cycle.
module mux_arb_2x1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x0_valid,
  input  logic [WIDTH-1:0] x0,
  output logic             x0_ready,
  input  logic             x1_valid,
  input  logic [WIDTH-1:0] x1,
  output logic             x1_ready,
  output logic             f_valid,
  output logic [WIDTH-1:0] f,
  output logic             s,
  input  logic             f_ready
);

  logic             f_valid_q, f_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             s_q, s_d;
  logic             last_grant_q, last_grant_d;

  logic             load_en;
  logic             grant_valid;
  logic             grant;

  // The register can take a new word when it is empty or its word leaves this cycle.
  assign load_en = !f_valid_q || f_ready;

  // Round-robin pick: a lone requester wins outright, a tie goes to the source that lost last time.
  always_comb begin
    grant_valid = x0_valid || x1_valid;
    grant       = 1'b0;
    if (x0_valid && x1_valid) begin
      grant = !last_grant_q;
    end else if (x1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready follows the real grant so at most one source is ever accepted; held low during reset.
  assign x0_ready = !rst && load_en && grant_valid && !grant;
  assign x1_ready = !rst && load_en && grant_valid &&  grant;

  // Next-state: capture the winner's word, drain to empty when idle, otherwise hold.
  always_comb begin
    f_valid_d    = f_valid_q;
    f_d          = f_q;
    s_d          = s_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      if (grant_valid) begin
        f_valid_d    = 1'b1;
        f_d          = grant ? x1 : x0;
        s_d          = grant;
        last_grant_d = grant;
      end else begin
        f_valid_d = 1'b0;
      end
    end
  end

  // Output register and arbitration history; reset discards any held word and favours source 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_valid_q    <= 1'b0;
      f_q          <= '0;
      s_q          <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      f_valid_q    <= f_valid_d;
      f_q          <= f_d;
      s_q          <= s_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign f_valid = f_valid_q;
  assign f       = f_q;
  assign s       = s_q;

endmodule

// File: tb/tb_mux_arb_2x1.sv
// Testbench for mux_arb_2x1: directed scenarios with hand-computed expectations,
// a reference model of the arbiter state, and a word scoreboard for a random run.
module tb_mux_arb_2x1;

  logic       clk;
  logic       rst;
  logic       x0_valid;
  logic [7:0] x0;
  logic       x0_ready;
  logic       x1_valid;
  logic [7:0] x1;
  logic       x1_ready;
  logic       f_valid;
  logic [7:0] f;
  logic       s;
  logic       f_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic       exp_fv;
  logic [7:0] exp_f;
  logic       exp_s;
  logic       exp_lg;

  // Accepted words {source, data} waiting to be seen on the output
  logic [8:0] sb[$];

  mux_arb_2x1 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .x0_valid (x0_valid),
    .x0       (x0),
    .x0_ready (x0_ready),
    .x1_valid (x1_valid),
    .x1       (x1),
    .x1_ready (x1_ready),
    .f_valid  (f_valid),
    .f        (f),
    .s        (s),
    .f_ready  (f_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hand-computed check of the output register, taken just after an edge
  task automatic checkHeld(input string tag, input logic ev, input logic [7:0] ef, input logic es);
    #1;
    checkOutput({tag, "_f_valid"}, f_valid, ev);
    checkOutput({tag, "_f"}, f, ef);
    checkOutput({tag, "_s"}, s, es);
  endtask

  // Pulse reset between edges with both sources requesting; everything must clear without a clock
  task automatic resetDut();
    #2;
    x0_valid = 1'b1;
    x1_valid = 1'b1;
    f_ready  = 1'b1;
    rst      = 1'b1;
    #1;
    checkOutput("rst_f_valid", f_valid, 1'b0);
    checkOutput("rst_f", f, 8'h00);
    checkOutput("rst_s", s, 1'b0);
    checkOutput("rst_x0_ready", x0_ready, 1'b0);
    checkOutput("rst_x1_ready", x1_ready, 1'b0);
    exp_fv = 1'b0;
    exp_f  = 8'h00;
    exp_s  = 1'b0;
    exp_lg = 1'b1;
    sb.delete();
    @(negedge clk);
    x0_valid = 1'b0;
    x1_valid = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check readies/outputs against the model, update scoreboard and model
  task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1, input logic fr);
    logic       load;
    logic       has_grant;
    logic       g;
    logic [8:0] head;
    @(negedge clk);
    x0_valid = v0;
    x0       = d0;
    x1_valid = v1;
    x1       = d1;
    f_ready  = fr;
    #1;
    load      = !exp_fv || fr;
    has_grant = v0 || v1;
    if (v0 && v1) g = !exp_lg;
    else          g = v1;
    checkOutput("x0_ready", x0_ready, load && has_grant && !g);
    checkOutput("x1_ready", x1_ready, load && has_grant && g);
    checkOutput("f_valid", f_valid, exp_fv);
    checkOutput("f", f, exp_f);
    checkOutput("s", s, exp_s);
    if (f_valid === 1'b1 && f_ready) begin
      checkOutput("sb_word_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        head = sb.pop_front();
        checkOutput("sb_word", {s, f}, head);
      end
    end
    if (x0_valid && x0_ready === 1'b1) sb.push_back({1'b0, x0});
    if (x1_valid && x1_ready === 1'b1) sb.push_back({1'b1, x1});
    @(posedge clk);
    if (load) begin
      if (has_grant) begin
        exp_fv = 1'b1;
        exp_f  = g ? d1 : d0;
        exp_s  = g;
        exp_lg = g;
      end else begin
        exp_fv = 1'b0;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    x0_valid = 1'b0;
    x1_valid = 1'b0;
    x0       = 8'hFF;
    x1       = 8'hEE;
    f_ready  = 1'b1;
    resetDut();

    $display("[TB] single source transfer");
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    checkHeld("s1_load", 1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'hA5, 1'b0, 8'h00, 1'b1);
    checkHeld("s1_idle", 1'b0, 8'hA5, 1'b0);

    $display("[TB] alternating grants");
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      checkHeld("s2_alt", 1'b1, (i % 2 == 1) ? 8'h22 : 8'h11, (i % 2 == 1));
    end

    $display("[TB] downstream stall");
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    checkHeld("s3_load", 1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
      checkHeld("s3_stall", 1'b1, 8'h11, 1'b0);
    end
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    checkHeld("s3_release", 1'b1, 8'h22, 1'b1);

    $display("[TB] lone source 1 then tie");
    applyStimulus(1'b0, 8'h99, 1'b1, 8'h01, 1'b1);
    checkHeld("s4_w1", 1'b1, 8'h01, 1'b1);
    applyStimulus(1'b0, 8'h98, 1'b1, 8'h02, 1'b1);
    checkHeld("s4_w2", 1'b1, 8'h02, 1'b1);
    applyStimulus(1'b0, 8'h97, 1'b1, 8'h03, 1'b1);
    checkHeld("s4_w3", 1'b1, 8'h03, 1'b1);
    applyStimulus(1'b1, 8'h77, 1'b1, 8'h44, 1'b1);
    checkHeld("s4_tie", 1'b1, 8'h77, 1'b0);

    $display("[TB] asynchronous reset while holding");
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
    checkHeld("s5_held", 1'b1, 8'h33, 1'b1);
    resetDut();
    applyStimulus(1'b1, 8'h5A, 1'b1, 8'hC3, 1'b1);
    checkHeld("s5_tie", 1'b1, 8'h5A, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    8'($urandom), ($urandom_range(0, 3) != 0));
    end
    checkOutput("sb_residual", sb.size(), exp_fv ? 1 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
